event_pulse_scheduler: RTL and testbench

Shares a single extended-pulse output line (the FPGA→Arduino event strobe) among up to NUM_EVENTS game-FSM event sources (jump, coin, hit, death, ...). Captures one-cycle event requests into a pending set, grants them one at a time in fixed priority, and drives a PULSE_WIDTH-cycle strobe with a stable event code, followed by a mandatory GAP_WIDTH-cycle low gap so the Arduino can separate back-to-back events. Sits between the game FSM event outputs and the Arduino GPIO pins, replacing per-event pulse stretching.

---
 rtl/event_pulse_scheduler.sv | 108 ++++++++++
 tb/tb_event_pulse_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/event_pulse_scheduler.sv
// Fixed-priority scheduler sharing one stretched event strobe among NUM_EVENTS sources.
// Strobe PULSE_WIDTH cycles one cycle after grant, then GAP_WIDTH forced-low cycles; requests stay pending meanwhile.
`timescale 1ns/1ps
module event_pulse_scheduler #(
  parameter int NUM_EVENTS  = 4,
  parameter int PULSE_WIDTH = 500000,
  parameter int GAP_WIDTH   = 250000,
  parameter int CODE_W      = $clog2(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] event_req,
  output logic                  pulse_out,
  output logic [CODE_W-1:0]     event_code,
  output logic                  busy,
  output logic                  coalesced
);
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  localparam logic [25:0] PW_M1 = 26'(PULSE_WIDTH - 1);
  localparam logic [25:0] GW_M1 = (GAP_WIDTH > 0) ? 26'(GAP_WIDTH - 1) : 26'd0;

  state_t                r_state, w_next_state;
  logic [25:0]           r_cnt, w_next_cnt;
  logic [NUM_EVENTS-1:0] r_pending, w_cand, w_grant_mask;
  logic [CODE_W-1:0]     r_code, w_winner;
  logic                  w_any, w_grant;
  logic                  r_pulse, r_busy, r_coal;

  assign w_cand = r_pending | event_req;
  assign w_any  = |w_cand;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (w_cand[i]) w_winner = CODE_W'(i);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant      = 1'b1;
          w_next_state = S_PULSE;
          w_next_cnt   = PW_M1;
        end
      end
      S_PULSE: begin
        if (r_cnt != '0) begin
          w_next_cnt = r_cnt - 26'd1;
        end else if (GAP_WIDTH > 0) begin
          w_next_state = S_GAP;
          w_next_cnt   = GW_M1;
        end else if (w_any) begin
          w_grant      = 1'b1;
          w_next_state = S_PULSE;
          w_next_cnt   = PW_M1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_next_cnt = r_cnt - 26'd1;
        end else if (w_any) begin
          w_grant      = 1'b1;
          w_next_state = S_PULSE;
          w_next_cnt   = PW_M1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_grant_mask = w_grant ? (NUM_EVENTS'(1) << w_winner) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pending <= '0;
      r_code    <= '0;
      r_pulse   <= 1'b0;
      r_busy    <= 1'b0;
      r_coal    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_pending <= w_cand & ~w_grant_mask;
      if (w_grant) r_code <= w_winner;
      r_pulse   <= (w_next_state == S_PULSE);
      r_busy    <= (w_next_state != S_IDLE);
      r_coal    <= |(event_req & r_pending & ~w_grant_mask);
    end
  end

  assign pulse_out  = r_pulse;
  assign event_code = r_code;
  assign busy       = r_busy;
  assign coalesced  = r_coal;
endmodule

// File: tb/tb_event_pulse_scheduler.sv
// Scoreboard bench: stimulus queues hand-computed strobes, coalesce flags and state probes;
// a negedge monitor pops and compares as the selected DUT produces them.
`timescale 1ns/1ps
module tb_event_pulse_scheduler;
  localparam int NE = 4;
  localparam int PW = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [NE-1:0] event_req = '0;
  bit            sel_gw0 = 1'b0;

  logic          p2_pulse, p2_busy, p2_coal, p0_pulse, p0_busy, p0_coal;
  logic [CW-1:0] p2_code, p0_code;
  logic          m_pulse, m_busy, m_coal;
  logic [CW-1:0] m_code;

  event_pulse_scheduler #(.NUM_EVENTS(NE), .PULSE_WIDTH(PW), .GAP_WIDTH(2), .CODE_W(CW)) u_dut_gap2 (
    .clk(clk), .rst(rst), .event_req(event_req), .pulse_out(p2_pulse),
    .event_code(p2_code), .busy(p2_busy), .coalesced(p2_coal));

  event_pulse_scheduler #(.NUM_EVENTS(NE), .PULSE_WIDTH(PW), .GAP_WIDTH(0), .CODE_W(CW)) u_dut_gap0 (
    .clk(clk), .rst(rst), .event_req(event_req), .pulse_out(p0_pulse),
    .event_code(p0_code), .busy(p0_busy), .coalesced(p0_coal));

  assign m_pulse = sel_gw0 ? p0_pulse : p2_pulse;
  assign m_code  = sel_gw0 ? p0_code  : p2_code;
  assign m_busy  = sel_gw0 ? p0_busy  : p2_busy;
  assign m_coal  = sel_gw0 ? p0_coal  : p2_coal;

  typedef struct { int start; int code; int len; } strobe_t;
  typedef struct { int cyc; bit pulse; int code; bit busy; bit coal; } probe_t;

  strobe_t exp_strobe_q[$];
  int      exp_coal_q[$];
  probe_t  probe_q[$];

  int cyc = 0;
  int drain_req = 0;
  int drain_done = 0;
  int n_pass = 0;
  int n_total = 0;
  bit seg_open = 1'b0;
  int seg_start, seg_code, seg_len;

  task automatic chk(input string name, input bit ok, input string act, input string req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  // Monitor: owns all comparisons and both counters.
  always @(negedge clk) begin
    strobe_t e;
    probe_t  p;
    int      ec;
    if (seg_open && (!m_pulse || int'(m_code) != seg_code)) begin
      seg_open = 1'b0;
      if (exp_strobe_q.size() == 0) begin
        chk("strobe", 1'b0, $sformatf("start=%0d code=%0d len=%0d", seg_start, seg_code, seg_len), "no strobe");
      end else begin
        e = exp_strobe_q.pop_front();
        chk("strobe", seg_start == e.start && seg_code == e.code && seg_len == e.len,
            $sformatf("start=%0d code=%0d len=%0d", seg_start, seg_code, seg_len),
            $sformatf("start=%0d code=%0d len=%0d", e.start, e.code, e.len));
      end
    end
    if (m_pulse && !seg_open) begin
      seg_open  = 1'b1;
      seg_start = cyc;
      seg_code  = int'(m_code);
      seg_len   = 0;
    end
    if (m_pulse) seg_len++;

    if (m_coal) begin
      if (exp_coal_q.size() == 0) begin
        chk("coalesced", 1'b0, $sformatf("flag at cycle %0d", cyc), "no flag");
      end else begin
        ec = exp_coal_q.pop_front();
        chk("coalesced", ec == cyc, $sformatf("flag at cycle %0d", cyc), $sformatf("cycle %0d", ec));
      end
    end

    if (probe_q.size() > 0 && probe_q[0].cyc == cyc) begin
      p = probe_q.pop_front();
      chk($sformatf("probe_c%0d", p.cyc),
          m_pulse == p.pulse && int'(m_code) == p.code && m_busy == p.busy && m_coal == p.coal,
          $sformatf("pulse=%0b code=%0d busy=%0b coal=%0b", m_pulse, m_code, m_busy, m_coal),
          $sformatf("pulse=%0b code=%0d busy=%0b coal=%0b", p.pulse, p.code, p.busy, p.coal));
    end

    if (drain_req != drain_done) begin
      drain_done = drain_req;
      chk("drain", exp_strobe_q.size() == 0 && exp_coal_q.size() == 0 && probe_q.size() == 0 && !seg_open,
          $sformatf("strobes=%0d coals=%0d probes=%0d open=%0b",
                    exp_strobe_q.size(), exp_coal_q.size(), probe_q.size(), seg_open),
          "all queues empty, no open strobe");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_scen(input bit gw0);
    rst       = 1'b1;
    event_req = '0;
    sel_gw0   = gw0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic req_at(input int c, input logic [NE-1:0] v);
    while (cyc < c) tick();
    event_req = v;
    tick();
    event_req = '0;
  endtask

  task automatic finish_scen(input int last);
    while (cyc < last) tick();
    drain_req++;
    tick();
  endtask

  task automatic exp_strobe(input int s, input int c, input int l);
    strobe_t e;
    e.start = s; e.code = c; e.len = l;
    exp_strobe_q.push_back(e);
  endtask

  task automatic exp_probe(input int c, input bit pl, input int code, input bit b, input bit co);
    probe_t p;
    p.cyc = c; p.pulse = pl; p.code = code; p.busy = b; p.coal = co;
    probe_q.push_back(p);
  endtask

  initial begin
    // Single request, plus reset values at cycle 0.
    start_scen(1'b0);
    exp_probe(0, 0, 0, 0, 0);
    exp_probe(1, 1, 0, 1, 0);
    exp_probe(5, 0, 0, 1, 0);
    exp_probe(6, 0, 0, 1, 0);
    exp_probe(7, 0, 0, 0, 0);
    exp_strobe(1, 0, 4);
    req_at(0, 4'b0001);
    finish_scen(10);

    // Priority between simultaneous requests.
    start_scen(1'b0);
    exp_strobe(1, 1, 4);
    exp_strobe(7, 2, 4);
    exp_probe(5, 0, 1, 1, 0);
    exp_probe(12, 0, 2, 1, 0);
    exp_probe(13, 0, 2, 0, 0);
    req_at(0, 4'b0110);
    finish_scen(16);

    // Re-request of the event being strobed: no coalesce, repeats after gap.
    start_scen(1'b0);
    exp_strobe(1, 0, 4);
    exp_strobe(7, 0, 4);
    exp_probe(3, 1, 0, 1, 0);
    exp_probe(6, 0, 0, 1, 0);
    req_at(0, 4'b0001);
    req_at(2, 4'b0001);
    finish_scen(14);

    // Coalesce: second request for a pending bit merges into one strobe.
    start_scen(1'b0);
    exp_strobe(1, 0, 4);
    exp_strobe(7, 3, 4);
    exp_coal_q.push_back(3);
    exp_probe(3, 1, 0, 1, 1);
    exp_probe(4, 1, 0, 1, 0);
    req_at(0, 4'b0001);
    req_at(1, 4'b1000);
    req_at(2, 4'b1000);
    finish_scen(16);

    // Requests during gap, including the last gap cycle: gap never shortened.
    start_scen(1'b0);
    exp_strobe(1, 0, 4);
    exp_strobe(7, 1, 4);
    exp_strobe(13, 2, 4);
    exp_probe(6, 0, 0, 1, 0);
    exp_probe(12, 0, 1, 1, 0);
    exp_probe(19, 0, 2, 0, 0);
    req_at(0, 4'b0001);
    req_at(5, 4'b0010);
    req_at(6, 4'b0100);
    finish_scen(22);

    // Zero gap: strobes run back to back.
    start_scen(1'b1);
    exp_strobe(1, 0, 4);
    exp_strobe(5, 1, 4);
    exp_probe(4, 1, 0, 1, 0);
    exp_probe(5, 1, 1, 1, 0);
    exp_probe(9, 0, 1, 0, 0);
    req_at(0, 4'b0011);
    finish_scen(12);

    // Reset mid-pulse discards the strobe and the pending request.
    start_scen(1'b0);
    exp_strobe(1, 0, 2);
    exp_probe(2, 1, 0, 1, 0);
    exp_probe(3, 0, 0, 0, 0);
    exp_probe(4, 0, 0, 0, 0);
    req_at(0, 4'b0101);
    while (cyc < 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    finish_scen(14);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
